// File: rtl/instr_fetch.sv
//==============================================================================
// Module      : instr_fetch
// Description : Fetch-stage initiator. Owns the PC, presents it to an
//               asynchronous-read instruction memory and registers the returned
//               word into the IF/ID latch. Handles decode stall, branch/jump
//               redirect with wrong-path flush, end-of-memory halt and
//               misaligned-target fault.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module instr_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned MEM_WORDS = 64,
  parameter logic [31:0] NOP_WORD  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [25:0] jump_index,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4,
  output logic        if_valid,
  output logic        halted,
  output logic        fault,
  output logic [31:0] fetch_count
);

  // First byte address past the end of instruction memory.
  localparam logic [31:0] MEM_LIMIT = 32'(MEM_WORDS * 4);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_HALT  = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] pc;

  logic [31:0] pc_plus4;
  logic [31:0] jump_target;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        target_misaligned;
  logic        pc_out_of_range;

  // Memory is read with zero latency, so the PC itself is the fetch address.
  assign imem_addr = pc;

  // Next-address arithmetic; jump keeps the region bits of the next fetch address.
  always_comb begin
    pc_plus4          = pc + 32'd4;
    jump_target       = {pc_plus4[31:28], jump_index, 2'b00};
    redirect          = branch_taken | jump;
    redirect_target   = branch_taken ? branch_target : jump_target;
    target_misaligned = (redirect_target[1:0] != 2'b00);
    pc_out_of_range   = (pc >= MEM_LIMIT);
  end

  // Fetch FSM: redirect beats stall beats normal advance; HALT/FAULT are sticky.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_RUN;
      pc          <= RESET_PC;
      if_instr    <= NOP_WORD;
      if_pc       <= 32'h0;
      if_pc_plus4 <= 32'h0;
      if_valid    <= 1'b0;
      halted      <= 1'b0;
      fault       <= 1'b0;
      fetch_count <= 32'h0;
    end else begin
      case (state)
        ST_RUN: begin
          if (redirect) begin
            // Both a good and a bad redirect squash the word in the latch.
            if_valid <= 1'b0;
            if_instr <= NOP_WORD;
            if (target_misaligned) begin
              state <= ST_FAULT;
              fault <= 1'b1;
            end else begin
              pc <= redirect_target;
            end
          end else if (stall) begin
            // Decode is not ready: everything holds.
            pc <= pc;
          end else if (pc_out_of_range) begin
            state    <= ST_HALT;
            halted   <= 1'b1;
            if_valid <= 1'b0;
            if_instr <= NOP_WORD;
          end else begin
            if_instr    <= imem_data;
            if_pc       <= pc;
            if_pc_plus4 <= pc_plus4;
            if_valid    <= 1'b1;
            pc          <= pc_plus4;
            fetch_count <= fetch_count + 32'd1;
          end
        end
        ST_HALT, ST_FAULT: begin
          // Fetch stopped until reset; keep the latch presenting a bubble.
          if_valid <= 1'b0;
          if_instr <= NOP_WORD;
        end
        default: begin
          state    <= ST_FAULT;
          fault    <= 1'b1;
          if_valid <= 1'b0;
          if_instr <= NOP_WORD;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch.sv
//==============================================================================
// Module      : tb_instr_fetch
// Description : Scoreboard bench for instr_fetch with a behavioural fetch model.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_instr_fetch;

  localparam int unsigned MEM_WORDS = 64;
  localparam logic [31:0] NOP       = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic        jump = 1'b0;
  logic [25:0] jump_index = 26'h0;
  logic [31:0] if_instr, if_pc, if_pc_plus4, fetch_count;
  logic        if_valid, halted, fault;

  instr_fetch #(.RESET_PC(32'h0), .MEM_WORDS(MEM_WORDS), .NOP_WORD(NOP)) dut (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_data(imem_data),
    .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_index(jump_index), .if_instr(if_instr), .if_pc(if_pc),
    .if_pc_plus4(if_pc_plus4), .if_valid(if_valid), .halted(halted),
    .fault(fault), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  // Instruction memory contents (random, fixed before reset release).
  logic [31:0] mem [MEM_WORDS];

  always_comb begin
    if (imem_addr < MEM_WORDS * 4) imem_data = mem[imem_addr[7:2]];
    else                           imem_data = 32'hDEAD_BEEF;
  end

  typedef struct {
    logic [31:0] pc, instr, ipc, ipc4, cnt;
    logic        valid, halted, fault;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state: "stopped" covers both halt and fault.
  exp_t m;
  bit   m_stopped;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m = '{pc: 32'h0, instr: NOP, ipc: 32'h0, ipc4: 32'h0, cnt: 32'h0,
          valid: 1'b0, halted: 1'b0, fault: 1'b0};
    m_stopped = 0;
  endtask

  // One clock edge of the fetch stage as described behaviourally.
  task automatic model_step(input bit s, input bit b, input logic [31:0] bt,
                            input bit j, input logic [25:0] ji);
    logic [31:0] nxt, tgt;
    nxt = m.pc + 32'd4;
    if (m_stopped) begin
      m.valid = 0; m.instr = NOP;
    end else if (b || j) begin
      tgt = b ? bt : {nxt[31:28], ji, 2'b00};
      m.valid = 0; m.instr = NOP;
      if (tgt % 4 != 0) begin m.fault = 1; m_stopped = 1; end
      else m.pc = tgt;
    end else if (s) begin
      // hold
    end else if (m.pc >= MEM_WORDS * 4) begin
      m.halted = 1; m_stopped = 1; m.valid = 0; m.instr = NOP;
    end else begin
      m.instr = mem[m.pc / 4];
      m.ipc   = m.pc;
      m.ipc4  = nxt;
      m.valid = 1;
      m.pc    = nxt;
      m.cnt   = m.cnt + 1;
    end
  endtask

  // Drive one cycle of stimulus at the falling edge and queue its expected result.
  task automatic cyc(input bit r, input bit s, input bit b, input logic [31:0] bt,
                     input bit j, input logic [25:0] ji);
    bit was_running;
    @(negedge clk);
    was_running = rst_n;
    rst_n = r; stall = s; branch_taken = b; branch_target = bt;
    jump = j; jump_index = ji;
    if (!r) begin
      model_reset();
      if (was_running) begin
        // Reset is asynchronous: outputs must clear before any clock edge.
        #1;
        chk("async_rst_valid", {31'h0, if_valid}, 32'h0);
        chk("async_rst_count", fetch_count, 32'h0);
        chk("async_rst_addr", imem_addr, 32'h0);
      end
    end else begin
      model_step(s, b, bt, j, ji);
    end
    q.push_back(m);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc(1, 0, 0, 32'h0, 0, 26'h0);
  endtask

  // Monitor: after every rising edge compare DUT outputs with the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("imem_addr", imem_addr, e.pc);
        chk("if_instr", if_instr, e.instr);
        chk("if_pc", if_pc, e.ipc);
        chk("if_pc_plus4", if_pc_plus4, e.ipc4);
        chk("if_valid", {31'h0, if_valid}, {31'h0, e.valid});
        chk("halted", {31'h0, halted}, {31'h0, e.halted});
        chk("fault", {31'h0, fault}, {31'h0, e.fault});
        chk("fetch_count", fetch_count, e.cnt);
        if (halted && fault) chk("halt_and_fault", 32'h1, 32'h0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit s, b, j;
    logic [31:0] bt;
    logic [25:0] ji;
    for (int i = 0; i < MEM_WORDS; i++) mem[i] = $urandom;
    model_reset();

    // Reset, then free run four fetches.
    cyc(0, 0, 0, 32'h0, 0, 26'h0);
    cyc(0, 0, 0, 32'h0, 0, 26'h0);
    run(4);
    // Stall three cycles at pc=0x10.
    for (int i = 0; i < 3; i++) cyc(1, 1, 0, 32'h0, 0, 26'h0);
    // Advance to 0x24, then branch to 0x38.
    run(5);
    cyc(1, 0, 1, 32'h38, 0, 26'h0);
    run(2);
    // Jump concurrent with stall: redirect wins (target 0x38).
    cyc(1, 1, 0, 32'h0, 1, 26'h0E);
    // Branch and jump together: branch wins.
    cyc(1, 0, 1, 32'h20, 1, 26'h30);
    // Run off the end of memory; later redirects ignored.
    run(70);
    cyc(1, 0, 1, 32'h10, 0, 26'h0);
    cyc(1, 0, 0, 32'h0, 1, 26'h4);
    run(2);
    // Misaligned target faults; then reset mid-run.
    cyc(0, 0, 0, 32'h0, 0, 26'h0);
    run(3);
    cyc(1, 0, 1, 32'h3A, 0, 26'h0);
    run(2);
    cyc(1, 0, 1, 32'h40, 0, 26'h0);
    cyc(0, 0, 0, 32'h0, 0, 26'h0);
    run(5);
    cyc(0, 0, 0, 32'h0, 0, 26'h0);
    run(3);

    // Randomized traffic with periodic resets to escape sticky stops.
    for (int i = 0; i < 500; i++) begin
      s  = ($urandom_range(0, 99) < 25);
      b  = ($urandom_range(0, 99) < 10);
      j  = ($urandom_range(0, 99) < 5);
      bt = 32'($urandom_range(0, 70)) * 4;
      if ($urandom_range(0, 99) < 4) bt = bt + 32'($urandom_range(1, 3));
      ji = 26'($urandom_range(0, 72));
      cyc((i % 60) != 0, s, b, bt, j, ji);
    end

    run(2);
    @(negedge clk);
    chk("queue_drained", 32'(q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
